// File: rtl/memory_pkg.sv
// Shared memory-subsystem types for the L1-TLB/L2-TLB channel plus the
// L2 TLB request handler's own entry, core-answer and state types.
package memory_pkg;

  localparam int VPN_LEN       = 27;
  localparam int PPN_LEN       = 44;
  localparam int PAGE_TYPE_LEN = 2;

  typedef logic [VPN_LEN-1:0]       vpn_t;
  typedef logic [PPN_LEN-1:0]       ppn_t;
  typedef logic [PAGE_TYPE_LEN-1:0] page_type_t;

  typedef enum logic {ITLB = 1'b0, DTLB = 1'b1} tlb_origin_e;

  typedef struct packed {
    logic        valid;
    vpn_t        vpn;
    tlb_origin_e origin;
  } l1tlb_l2tlb_req_t;

  typedef struct packed {
    logic        valid;
    vpn_t        vpn;
    ppn_t        ppn;
    page_type_t  page_type;
    logic        exception;
    logic        r, w, x, d, g, u;
    tlb_origin_e destination;
  } l2tlb_l1tlb_ans_t;

  typedef struct packed {
    ppn_t       ppn;
    page_type_t page_type;
    logic       exception;
    logic       r, w, x, d, g, u;
  } l2tlb_core_ans_t;

  typedef struct packed {
    vpn_t        vpn;
    tlb_origin_e origin;
  } l2tlb_req_entry_t;

  typedef enum logic [2:0] {
    IDLE, ISSUE, WAIT_CORE, RESP, DRAIN
  } l2tlb_req_handler_state_e;

endpackage

// File: rtl/l2tlb_req_fifo.sv
// Synchronous request FIFO; pointers carry an extra wrap bit so full/empty
// are exact. Flush clears both pointers and wins over push/pop.
module l2tlb_req_fifo
  import memory_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  l2tlb_req_entry_t data_i,
  input  logic             pop_i,
  output l2tlb_req_entry_t data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, rptr_q;
  l2tlb_req_entry_t mem_q [DEPTH];

  logic do_push, do_pop;
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign data_o  = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rptr_q <= rptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/l2tlb_req_handler.sv
// L2 TLB side of the L1/L2 TLB channel: queues requests, runs them through
// the lookup core one at a time and holds each answer until L1 takes it.
module l2tlb_req_handler
  import memory_pkg::*;
#(
  parameter int REQ_FIFO_DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  l1tlb_l2tlb_req_t l1tlb_l2tlb_req_i,
  output logic             l2tlb_l1tlb_req_rdy_o,
  output l2tlb_l1tlb_ans_t l2tlb_l1tlb_ans_o,
  input  logic             l1tlb_l2tlb_ans_rdy_i,
  output logic             core_req_valid_o,
  output logic [VPN_LEN-1:0] core_req_vpn_o,
  input  logic             core_req_rdy_i,
  input  l2tlb_core_ans_t  core_ans_i,
  input  logic             core_ans_valid_i,
  output logic             core_ans_rdy_o
);
  l2tlb_req_handler_state_e state_q, state_d;
  l2tlb_req_entry_t         head, out_q;
  l2tlb_l1tlb_ans_t         ans_q;
  logic fifo_full, fifo_empty, push, pop, ld_out, ld_ans, clr_ans;

  // Ready ignores a same-cycle pop to keep the accept path short.
  assign l2tlb_l1tlb_req_rdy_o = !fifo_full && !flush_i;
  assign push = l1tlb_l2tlb_req_i.valid && l2tlb_l1tlb_req_rdy_o;

  l2tlb_req_fifo #(.DEPTH(REQ_FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (push),
    .data_i  ('{vpn: l1tlb_l2tlb_req_i.vpn, origin: l1tlb_l2tlb_req_i.origin}),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign core_req_vpn_o    = head.vpn;
  assign l2tlb_l1tlb_ans_o = ans_q;

  always_comb begin
    state_d          = state_q;
    pop              = 1'b0;
    ld_out           = 1'b0;
    ld_ans           = 1'b0;
    clr_ans          = 1'b0;
    core_req_valid_o = 1'b0;
    core_ans_rdy_o   = 1'b0;
    unique case (state_q)
      IDLE: if (!fifo_empty) state_d = ISSUE;
      ISSUE: begin
        core_req_valid_o = 1'b1;
        if (core_req_rdy_i) begin
          pop     = 1'b1;
          ld_out  = 1'b1;
          state_d = WAIT_CORE;
        end
      end
      WAIT_CORE: begin
        core_ans_rdy_o = 1'b1;
        if (core_ans_valid_i) begin
          ld_ans  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: if (l1tlb_l2tlb_ans_rdy_i) begin
        clr_ans = 1'b1;
        state_d = fifo_empty ? IDLE : ISSUE;
      end
      DRAIN: begin
        core_ans_rdy_o = 1'b1;
        if (core_ans_valid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A core transaction already handed off must still be drained; one that
    // completes in the flush cycle itself is simply discarded.
    if (flush_i) begin
      ld_ans  = 1'b0;
      clr_ans = 1'b1;
      case (state_q)
        IDLE:      state_d = IDLE;
        ISSUE:     state_d = core_req_rdy_i ? DRAIN : IDLE;
        WAIT_CORE: state_d = core_ans_valid_i ? IDLE : DRAIN;
        RESP:      state_d = IDLE;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      out_q   <= '0;
      ans_q   <= '0;
    end else begin
      state_q <= state_d;
      if (ld_out) out_q <= head;
      if (ld_ans) begin
        ans_q <= '{valid: 1'b1, vpn: out_q.vpn, ppn: core_ans_i.ppn,
                   page_type: core_ans_i.page_type, exception: core_ans_i.exception,
                   r: core_ans_i.r, w: core_ans_i.w, x: core_ans_i.x,
                   d: core_ans_i.d, g: core_ans_i.g, u: core_ans_i.u,
                   destination: out_q.origin};
      end else if (clr_ans) begin
        ans_q.valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_l2tlb_req_handler.sv
// Scoreboard bench for l2tlb_req_handler with a behavioural lookup core.
module tb_l2tlb_req_handler;
  import memory_pkg::*;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b1;
  logic flush_i;
  l1tlb_l2tlb_req_t req;
  logic req_rdy;
  l2tlb_l1tlb_ans_t ans;
  logic ans_rdy;
  logic core_req_valid;
  logic [VPN_LEN-1:0] core_req_vpn;
  logic core_req_rdy;
  l2tlb_core_ans_t core_ans;
  logic core_ans_valid;
  logic core_ans_rdy;

  always #5 clk_i = ~clk_i;

  l2tlb_req_handler #(.REQ_FIFO_DEPTH(2)) dut (
    .clk_i                 (clk_i),
    .rst_ni                (rst_ni),
    .flush_i               (flush_i),
    .l1tlb_l2tlb_req_i     (req),
    .l2tlb_l1tlb_req_rdy_o (req_rdy),
    .l2tlb_l1tlb_ans_o     (ans),
    .l1tlb_l2tlb_ans_rdy_i (ans_rdy),
    .core_req_valid_o      (core_req_valid),
    .core_req_vpn_o        (core_req_vpn),
    .core_req_rdy_i        (core_req_rdy),
    .core_ans_i            (core_ans),
    .core_ans_valid_i      (core_ans_valid),
    .core_ans_rdy_o        (core_ans_rdy)
  );

  int n_cmp = 0, n_err = 0;
  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  l2tlb_l1tlb_ans_t exp_q[$];
  l2tlb_core_ans_t  core_tab [vpn_t];
  int core_lat = 1;

  function automatic l2tlb_core_ans_t mk_core(input ppn_t ppn, input page_type_t pt,
                                              input logic exc, input logic [5:0] perm);
    l2tlb_core_ans_t c;
    c.ppn = ppn; c.page_type = pt; c.exception = exc;
    {c.r, c.w, c.x, c.d, c.g, c.u} = perm;
    return c;
  endfunction

  // Lookup core model: accepts a request, answers core_lat cycles later.
  logic cm_busy, cm_rq, cm_ah;
  int   cm_cnt;
  vpn_t cm_vpn, cm_v;
  initial begin
    core_ans_valid = 1'b0; core_ans = '0; cm_busy = 1'b0; cm_cnt = 0; cm_vpn = '0;
    forever begin
      @(negedge clk_i);
      cm_rq = core_req_valid && core_req_rdy;
      cm_ah = core_ans_valid && core_ans_rdy;
      cm_v  = core_req_vpn;
      @(posedge clk_i); #1;
      if (!rst_ni) begin
        cm_busy = 1'b0; core_ans_valid = 1'b0;
      end else begin
        if (cm_ah) begin core_ans_valid = 1'b0; cm_busy = 1'b0; end
        if (cm_rq) begin cm_busy = 1'b1; cm_cnt = core_lat; cm_vpn = cm_v; end
        else if (cm_busy && !core_ans_valid) begin
          if (cm_cnt <= 1) begin
            core_ans_valid = 1'b1;
            core_ans = core_tab.exists(cm_vpn) ? core_tab[cm_vpn] : '0;
          end else cm_cnt--;
        end
      end
    end
  end

  // Answer monitor / scoreboard and event timestamps.
  l2tlb_l1tlb_ans_t mon_e;
  logic creq_prev = 1'b0, ans_prev = 1'b0;
  int t_creq = 0, t_cans = 0, t_ans = 0, n_ans_rise = 0, t_acc = 0;
  always @(negedge clk_i) begin
    if (rst_ni && ans.valid && ans_rdy) begin
      if (exp_q.size() == 0) chk("unexpected_answer", {63'd0, ans.valid}, 64'd0);
      else begin
        mon_e = exp_q.pop_front();
        chk("ans_vpn", 64'(ans.vpn), 64'(mon_e.vpn));
        chk("ans_ppn", 64'(ans.ppn), 64'(mon_e.ppn));
        chk("ans_dest", 64'(ans.destination), 64'(mon_e.destination));
        chk("ans_flags", 64'({ans.page_type, ans.exception, ans.r, ans.w, ans.x, ans.d, ans.g, ans.u}),
            64'({mon_e.page_type, mon_e.exception, mon_e.r, mon_e.w, mon_e.x, mon_e.d, mon_e.g, mon_e.u}));
      end
    end
    if (core_req_valid && !creq_prev) t_creq <= cyc;
    if (core_ans_valid && core_ans_rdy) t_cans <= cyc;
    if (ans.valid && !ans_prev) begin t_ans <= cyc; n_ans_rise <= n_ans_rise + 1; end
    creq_prev <= core_req_valid;
    ans_prev  <= ans.valid;
  end

  // Drive one request until accepted; on acceptance queue its expected answer.
  task automatic send(input vpn_t vpn, input tlb_origin_e org, output int waits);
    l2tlb_l1tlb_ans_t e;
    l2tlb_core_ans_t  c;
    logic acc;
    c = core_tab.exists(vpn) ? core_tab[vpn] : '0;
    req.valid = 1'b1; req.vpn = vpn; req.origin = org; waits = 0;
    forever begin
      @(negedge clk_i);
      acc = req_rdy;
      if (acc) begin
        t_acc = cyc;
        e = '{valid: 1'b1, vpn: vpn, ppn: c.ppn, page_type: c.page_type, exception: c.exception,
              r: c.r, w: c.w, x: c.x, d: c.d, g: c.g, u: c.u, destination: org};
        exp_q.push_back(e);
      end
      @(posedge clk_i); #1;
      if (acc) break;
      waits++;
      if (waits > 60) begin chk("send_timeout", 64'(waits), 64'd0); break; end
    end
    req.valid = 1'b0;
  endtask

  task automatic wait_drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 200) begin @(posedge clk_i); k++; end
    chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    #1;
  endtask

  task automatic wait_ans_valid(input string name);
    int k = 0;
    do begin @(negedge clk_i); k++; end while (!ans.valid && k < 40);
    chk(name, {63'd0, ans.valid}, 64'd1);
  endtask

  int w, w3, rises, k;
  logic found;
  l2tlb_l1tlb_ans_t snap;

  initial begin
    flush_i = 1'b0; req = '0; core_req_rdy = 1'b0; ans_rdy = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    chk("rst_ans_valid", {63'd0, ans.valid}, 64'd0);
    chk("rst_core_req_valid", {63'd0, core_req_valid}, 64'd0);
    chk("rst_core_ans_rdy", {63'd0, core_ans_rdy}, 64'd0);
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(negedge clk_i);
    chk("post_rst_req_rdy", {63'd0, req_rdy}, 64'd1);
    chk("post_rst_ans_valid", {63'd0, ans.valid}, 64'd0);
    @(posedge clk_i); #1;

    // Single ITLB request, latency checks.
    core_tab[27'h12345] = mk_core(44'hABCDE, 2'b00, 1'b0, 6'b101011);
    core_tab[27'h1]     = mk_core(44'h111, 2'b01, 1'b0, 6'b110000);
    core_tab[27'h2]     = mk_core(44'h222, 2'b10, 1'b1, 6'b000000);
    core_tab[27'h3]     = mk_core(44'h333, 2'b00, 1'b0, 6'b011101);
    core_tab[27'h0AAAA] = mk_core(44'hF0F0F, 2'b01, 1'b0, 6'b111111);
    core_tab[27'h0BBBB] = mk_core(44'h0C0C0, 2'b00, 1'b0, 6'b100001);
    core_tab[27'h777]   = mk_core(44'h7777, 2'b00, 1'b0, 6'b111000);
    core_tab[27'h9999]  = mk_core(44'h9999, 2'b10, 1'b0, 6'b010101);
    core_tab[27'h4321]  = mk_core(44'h8765, 2'b01, 1'b0, 6'b001110);
    core_req_rdy = 1'b1; ans_rdy = 1'b1; core_lat = 2;
    send(27'h12345, ITLB, w);
    wait_drain();
    chk("t1_req_to_core_lat", 64'(t_creq - t_acc), 64'd2);
    chk("t1_core_to_ans_lat", 64'(t_ans - t_cans), 64'd1);

    // Fill the FIFO while the core stalls; answers must return in order.
    core_req_rdy = 1'b0; core_lat = 1;
    send(27'h1, DTLB, w);  chk("t2_r1_wait", 64'(w), 64'd0);
    send(27'h2, ITLB, w);  chk("t2_r2_wait", 64'(w), 64'd0);
    fork
      send(27'h3, DTLB, w3);
      begin repeat (4) @(posedge clk_i); #1 core_req_rdy = 1'b1; end
    join
    chk("t2_full_backpressure", {63'd0, (w3 >= 4)}, 64'd1);
    wait_drain();

    // Answer held while L1 is not ready; no new lookup issued meanwhile.
    ans_rdy = 1'b0;
    send(27'h0AAAA, ITLB, w);
    send(27'h0BBBB, DTLB, w);
    wait_ans_valid("t3_ans_valid");
    snap = ans;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("t3_hold_stable", {63'd0, (ans === snap)}, 64'd1);
      chk("t3_no_issue", {63'd0, core_req_valid}, 64'd0);
    end
    @(posedge clk_i); #1 ans_rdy = 1'b1;
    wait_drain();

    // Flush while waiting on the core: result drained, no answer.
    core_lat = 4;
    send(27'h777, DTLB, w);
    k = 0;
    do begin @(negedge clk_i); k++; end while (!core_ans_rdy && k < 20);
    chk("t4_in_wait", {63'd0, core_ans_rdy}, 64'd1);
    @(posedge clk_i); #1 flush_i = 1'b1;
    @(posedge clk_i); #1 flush_i = 1'b0;
    exp_q.delete();
    rises = n_ans_rise;
    found = 1'b0; k = 0;
    while (!found && k < 20) begin
      @(negedge clk_i); k++;
      found = core_ans_valid && core_ans_rdy;
    end
    chk("t4_drain_consume", {63'd0, found}, 64'd1);
    repeat (3) @(negedge clk_i);
    chk("t4_no_answer", 64'(n_ans_rise - rises), 64'd0);
    chk("t4_state_idle", 64'(dut.state_q), 64'(IDLE));
    chk("t4_fifo_empty", {63'd0, dut.fifo_empty}, 64'd1);
    @(posedge clk_i); #1;

    // Flush coincident with a request: not accepted.
    core_lat = 1;
    req.valid = 1'b1; req.vpn = 27'h555; req.origin = ITLB; flush_i = 1'b1;
    @(negedge clk_i);
    chk("t5_rdy_low", {63'd0, req_rdy}, 64'd0);
    @(posedge clk_i); #1 req.valid = 1'b0; flush_i = 1'b0;
    @(negedge clk_i);
    chk("t5_fifo_empty", {63'd0, dut.fifo_empty}, 64'd1);
    chk("t5_rdy_back", {63'd0, req_rdy}, 64'd1);
    repeat (2) begin
      @(negedge clk_i);
      chk("t5_no_issue", {63'd0, core_req_valid}, 64'd0);
    end
    @(posedge clk_i); #1;

    // Asynchronous reset in the middle of RESP.
    ans_rdy = 1'b0;
    send(27'h9999, ITLB, w);
    wait_ans_valid("t6_ans_valid");
    @(posedge clk_i); #2 rst_ni = 1'b0;
    #1;
    chk("t6_async_clear", {63'd0, ans.valid}, 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(negedge clk_i);
    chk("t6_rdy_after", {63'd0, req_rdy}, 64'd1);
    chk("t6_fifo_empty", {63'd0, dut.fifo_empty}, 64'd1);
    chk("t6_ans_low", {63'd0, ans.valid}, 64'd0);
    @(posedge clk_i); #1;

    // Normal operation resumes after reset.
    ans_rdy = 1'b1;
    send(27'h4321, DTLB, w);
    wait_drain();

    repeat (2) @(posedge clk_i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
